// File: rtl/gemm_c_tile_writeback.sv
// Buffers completed GeMM output tiles and streams them element by element,
// row-major, onto a back-pressured word-wide write port toward SRAM C.
module gemm_c_tile_writeback #(
  parameter int unsigned OutDataWidth  = 32,
  parameter int unsigned M             = 4,
  parameter int unsigned N             = 4,
  parameter int unsigned AddrWidth     = 16,
  parameter int unsigned SizeAddrWidth = 8,
  parameter int unsigned Depth         = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            tile_valid_i,
  input  logic [SizeAddrWidth-1:0]        tile_row_i,
  input  logic [SizeAddrWidth-1:0]        tile_col_i,
  input  logic [OutDataWidth*M*N-1:0]     tile_data_i,
  input  logic [SizeAddrWidth-1:0]        N_size_i,
  output logic                            tile_ready_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [AddrWidth-1:0]            out_addr_o,
  output logic [OutDataWidth-1:0]         out_data_o,
  output logic [$clog2(Depth+1)-1:0]      tiles_pending_o,
  output logic                            busy_o,
  output logic                            overflow_o
);

  localparam int unsigned TileWidth = OutDataWidth * M * N;
  localparam int unsigned CntWidth  = $clog2(Depth + 1);
  localparam int unsigned PtrWidth  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned MW        = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned NW        = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned EW        = (M * N > 1) ? $clog2(M * N) : 1;

  typedef enum logic {Idle, Drain} state_e;

  state_e                   state_q, state_d;
  logic [CntWidth-1:0]      count_q, count_d;
  logic [PtrWidth-1:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [MW-1:0]            mIdx_q, mIdx_d;
  logic [NW-1:0]            nIdx_q, nIdx_d;
  logic                     overflow_q, overflow_d;

  logic [TileWidth-1:0]     tileMem [Depth];
  logic [SizeAddrWidth-1:0] rowMem  [Depth];
  logic [SizeAddrWidth-1:0] colMem  [Depth];

  logic push, handshake, lastElem, pop;

  function automatic logic [PtrWidth-1:0] nextPtr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign tile_ready_o = (count_q < CntWidth'(Depth));
  assign push         = tile_valid_i && tile_ready_o;
  assign out_valid_o  = (state_q == Drain);
  assign handshake    = out_valid_o && out_ready_i;
  assign lastElem     = (mIdx_q == MW'(M - 1)) && (nIdx_q == NW'(N - 1));
  assign pop          = handshake && lastElem;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    mIdx_d     = mIdx_q;
    nIdx_d     = nIdx_q;
    overflow_d = overflow_q | (tile_valid_i && !tile_ready_o);

    if (push) wrPtr_d = nextPtr(wrPtr_q);
    if (pop)  rdPtr_d = nextPtr(rdPtr_q);
    if (push && !pop)      count_d = count_q + CntWidth'(1);
    else if (pop && !push) count_d = count_q - CntWidth'(1);

    // A same-cycle push keeps the drain going into the next tile without a bubble
    case (state_q)
      Idle: begin
        if (push) begin
          state_d = Drain;
          mIdx_d  = '0;
          nIdx_d  = '0;
        end
      end
      Drain: begin
        if (handshake) begin
          if (nIdx_q == NW'(N - 1)) begin
            nIdx_d = '0;
            if (mIdx_q == MW'(M - 1)) begin
              mIdx_d = '0;
              if (count_q == CntWidth'(1) && !push) state_d = Idle;
            end else begin
              mIdx_d = mIdx_q + MW'(1);
            end
          end else begin
            nIdx_d = nIdx_q + NW'(1);
          end
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= Idle;
      count_q    <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      mIdx_q     <= '0;
      nIdx_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      mIdx_q     <= mIdx_d;
      nIdx_q     <= nIdx_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q alone
  always_ff @(posedge clk_i) begin
    if (push) begin
      tileMem[wrPtr_q] <= tile_data_i;
      rowMem[wrPtr_q]  <= tile_row_i;
      colMem[wrPtr_q]  <= tile_col_i;
    end
  end

  logic [TileWidth-1:0]    headTile;
  logic [OutDataWidth-1:0] headElems [M*N];
  logic [EW-1:0]           elemIdx;
  logic [AddrWidth-1:0]    rowAbs, elemAddr;

  assign headTile = tileMem[rdPtr_q];

  for (genvar e = 0; e < M * N; e++) begin : gElem
    assign headElems[e] = headTile[e*OutDataWidth +: OutDataWidth];
  end

  assign elemIdx  = EW'(mIdx_q) * EW'(N) + EW'(nIdx_q);
  assign rowAbs   = AddrWidth'(rowMem[rdPtr_q]) * AddrWidth'(M) + AddrWidth'(mIdx_q);
  assign elemAddr = rowAbs * AddrWidth'(N_size_i)
                  + AddrWidth'(colMem[rdPtr_q]) * AddrWidth'(N) + AddrWidth'(nIdx_q);

  assign out_addr_o      = out_valid_o ? elemAddr : '0;
  assign out_data_o      = out_valid_o ? headElems[elemIdx] : '0;
  assign tiles_pending_o = count_q;
  assign busy_o          = (count_q != '0);
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_gemm_c_tile_writeback.sv
// Scoreboard bench for gemm_c_tile_writeback: expected words are queued when a
// tile is issued and a negedge monitor checks every presented word against them.
module tb_gemm_c_tile_writeback;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         tileValid, tileValidW;
  logic [7:0]   tileRow, tileCol, nSize;
  logic [511:0] tileData;
  logic         outReady;

  logic         tileReady, outValid, busy, overflow;
  logic [15:0]  outAddr;
  logic [31:0]  outData;
  logic [1:0]   pending;

  logic         tileReadyW, outValidW, busyW, overflowW;
  logic [7:0]   outAddrW;
  logic [31:0]  outDataW;
  logic [1:0]   pendingW;
  logic [7:0]   nSizeW = 8'd200;
  logic         outReadyW = 1'b1;

  exp_t sb[$];
  exp_t monE;
  int   checkCount = 0;
  int   passCount  = 0;
  int   hsCount    = 0;
  int   run        = 0;
  int   maxRun     = 0;

  always #5 clk = ~clk;

  gemm_c_tile_writeback dut (
    .clk_i(clk), .rst_i(rst), .tile_valid_i(tileValid), .tile_row_i(tileRow),
    .tile_col_i(tileCol), .tile_data_i(tileData), .N_size_i(nSize),
    .tile_ready_o(tileReady), .out_valid_o(outValid), .out_ready_i(outReady),
    .out_addr_o(outAddr), .out_data_o(outData), .tiles_pending_o(pending),
    .busy_o(busy), .overflow_o(overflow)
  );

  gemm_c_tile_writeback #(.AddrWidth(8)) dutW (
    .clk_i(clk), .rst_i(rst), .tile_valid_i(tileValidW), .tile_row_i(tileRow),
    .tile_col_i(tileCol), .tile_data_i(tileData), .N_size_i(nSizeW),
    .tile_ready_o(tileReadyW), .out_valid_o(outValidW), .out_ready_i(outReadyW),
    .out_addr_o(outAddrW), .out_data_o(outDataW), .tiles_pending_o(pendingW),
    .busy_o(busyW), .overflow_o(overflowW)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  function automatic logic [511:0] makeTile(input int base);
    logic [511:0] t = '0;
    for (int m = 0; m < 4; m++)
      for (int n = 0; n < 4; n++)
        t[(m*4+n)*32 +: 32] = 32'(base + m*16 + n);
    return t;
  endfunction

  // Issue one tile on the main DUT; accepted tiles queue their 16 expected words
  task automatic applyStimulus(input int row, input int col, input int base, input bit accept);
    tileRow   = 8'(row);
    tileCol   = 8'(col);
    tileData  = makeTile(base);
    tileValid = 1'b1;
    if (accept)
      for (int m = 0; m < 4; m++)
        for (int n = 0; n < 4; n++)
          sb.push_back('{addr: 16'(((row*4+m)*int'(nSize) + col*4 + n) % 65536),
                         data: 32'(base + m*16 + n)});
    @(posedge clk); #1;
    tileValid = 1'b0;
  endtask

  task automatic waitDrain(input bit toggle);
    int cyc = 0;
    while (sb.size() != 0 && cyc < 1000) begin
      outReady = toggle ? (cyc % 3 == 0) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    outReady = 1'b1;
    checkOutput("drainDone", 32'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (outValid) begin
        run++;
        if (run > maxRun) maxRun = run;
      end else begin
        run = 0;
      end
      if (outValid && outReady) begin
        hsCount++;
        if (sb.size() == 0) begin
          checkOutput("unexpectedWord", 1, 0);
        end else begin
          monE = sb.pop_front();
          checkOutput("addr", 32'(outAddr), 32'(monE.addr));
          checkOutput("data", outData, monE.data);
        end
      end else if (outValid && sb.size() != 0) begin
        checkOutput("stallAddr", 32'(outAddr), 32'(sb[0].addr));
        checkOutput("stallData", outData, sb[0].data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; tileValid = 1'b0; tileValidW = 1'b0; outReady = 1'b1;
    nSize = 8'd8; tileRow = '0; tileCol = '0; tileData = '0;
    @(posedge clk); #1;
    checkOutput("rstValid", 32'(outValid), 0);
    checkOutput("rstPending", 32'(pending), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstOverflow", 32'(overflow), 0);
    checkOutput("rstAddr", 32'(outAddr), 0);
    checkOutput("rstTileReady", 32'(tileReady), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] single tile");
    applyStimulus(1, 1, 0, 1'b1);
    checkOutput("latencyValid", 32'(outValid), 1);
    checkOutput("busyAfterPush", 32'(busy), 1);
    waitDrain(1'b0);
    checkOutput("idleBusy", 32'(busy), 0);
    checkOutput("idlePending", 32'(pending), 0);

    $display("[TB] back-pressure");
    hsCount = 0;
    outReady = 1'b1;
    applyStimulus(1, 1, 0, 1'b1);
    waitDrain(1'b1);
    checkOutput("bpHandshakes", 32'(hsCount), 16);

    $display("[TB] back-to-back tiles");
    maxRun = 0;
    applyStimulus(2, 1, 256, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    applyStimulus(0, 1, 512, 1'b1);
    waitDrain(1'b0);
    checkOutput("noBubbleRun", 32'(maxRun), 32);

    $display("[TB] overflow");
    outReady = 1'b0;
    applyStimulus(0, 0, 768, 1'b1);
    applyStimulus(1, 0, 1024, 1'b1);
    checkOutput("fullTileReady", 32'(tileReady), 0);
    checkOutput("noOverflowYet", 32'(overflow), 0);
    applyStimulus(3, 1, 1280, 1'b0);
    checkOutput("overflowSet", 32'(overflow), 1);
    checkOutput("fullPending", 32'(pending), 2);
    hsCount = 0;
    waitDrain(1'b0);
    checkOutput("overflowDrained", 32'(hsCount), 32);
    checkOutput("overflowSticky", 32'(overflow), 1);

    $display("[TB] reset mid-drain");
    hsCount = 0;
    applyStimulus(1, 2, 1536, 1'b1);
    applyStimulus(2, 2, 1792, 1'b1);
    cyc = 0;
    while (hsCount < 5 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checkOutput("midDrainReached", 32'(hsCount >= 5), 1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("mrValid", 32'(outValid), 0);
    checkOutput("mrPending", 32'(pending), 0);
    checkOutput("mrOverflow", 32'(overflow), 0);
    checkOutput("mrBusy", 32'(busy), 0);
    checkOutput("mrAddr", 32'(outAddr), 0);
    checkOutput("mrData", outData, 0);
    applyStimulus(3, 0, 2048, 1'b1);
    waitDrain(1'b0);

    $display("[TB] address wrap");
    tileRow = 8'd1; tileCol = 8'd0; tileData = makeTile(4096);
    tileValidW = 1'b1;
    @(posedge clk); #1;
    tileValidW = 1'b0;
    checkOutput("wrapValid", 32'(outValidW), 1);
    checkOutput("wrapAddr0", 32'(outAddrW), 32);
    checkOutput("wrapData0", outDataW, 4096);
    @(posedge clk); #1;
    checkOutput("wrapAddr1", 32'(outAddrW), 33);
    checkOutput("wrapData1", outDataW, 4097);

    repeat (20) begin @(posedge clk); #1; end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/gemm_c_tile_writeback.md
Name: gemm_c_tile_writeback

Overview:
- Sits directly downstream of the GeMM accelerator top.
- Captures each completed MxN output tile, presented as a wide word of OutDataWidth*M*N bits on the result-valid pulse, into a small tile buffer.
- Serializes each buffered tile element by element onto a narrow valid/ready write port toward a word-wide SRAM C, computing the row-major element address of each word.
- Decouples the accelerator's single-cycle result pulse from a back-pressured memory.

Parameters:
OutDataWidth, 32, width of one result element
M, 4, tile rows
N, 4, tile columns
AddrWidth, 16, element address width
SizeAddrWidth, 8, width of matrix-size and tile-index inputs
Depth, 2, tile buffer slots (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
tile_valid_i  in  1  tile present this cycle (single-cycle pulse from accelerator result-valid)
tile_row_i  in  SizeAddrWidth  tile row index (M_count)
tile_col_i  in  SizeAddrWidth  tile column index (N_count)
tile_data_i  in  OutDataWidth*M*N  tile; element (m,n) at bits [(m*N+n)*OutDataWidth +: OutDataWidth]
N_size_i  in  SizeAddrWidth  full C row length in elements; static during operation
tile_ready_o  out  1  a buffer slot is free
out_valid_o  out  1  write word valid
out_ready_i  in  1  memory accepts word
out_addr_o  out  AddrWidth  element address
out_data_o  out  OutDataWidth  element data
tiles_pending_o  out  $clog2(Depth+1)  occupied slots, including the tile being drained
busy_o  out  1  tiles_pending_o != 0
overflow_o  out  1  sticky: a tile was dropped

Behaviour:
Reset:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- All outputs 0 in the cycle after rst_i is sampled high; slots emptied; element index 0.
- Reset mid-drain discards all buffered tiles. No partial word is emitted after reset.

Tile buffer (circular FIFO of Depth entries):
- Each entry stores data, row and col.
- tile_ready_o = (tiles_pending_o < Depth). It is registered-state based only and does not depend on out_ready_i.
- Push: tile_valid_i && tile_ready_o. The entry is written at the clock edge.
- tile_valid_i while full: the tile is dropped, overflow_o is set, and state is otherwise unchanged. overflow_o clears only on reset.
- Push and pop in the same cycle: count unchanged, both take effect.

Drain state machine (IDLE, DRAIN):
- IDLE: out_valid_o=0. When the FIFO becomes non-empty, enter DRAIN with index (m,n)=(0,0).
- Latency: a tile pushed at edge t into an empty buffer gives out_valid_o=1 during cycle t+1.
- DRAIN: out_valid_o=1 with the head tile's element (m,n). Order is n inner, m outer.
- Handshake = out_valid_o && out_ready_i. Index advances only on a handshake.
- out_addr_o and out_data_o are held stable while out_valid_o && !out_ready_i.
- Handshake at (M-1,N-1): pop the head. If the FIFO is still non-empty (counting a same-cycle push), stay in DRAIN at (0,0) of the next tile with no bubble cycle. Otherwise go to IDLE.

Address:
- out_addr_o = ((tile_row*M + m) * N_size_i + tile_col*N + n) mod 2^AddrWidth.
- Computed at AddrWidth bits; overflow wraps silently.
- Either register the address or compute it combinationally from registered state. No combinational path from out_ready_i to out_addr_o or out_data_o.

Throughput: one word per cycle under continuous out_ready_i; M*N cycles per tile.

Test Plan:
- Addresses and data, single tile: Depth=2, M=N=4, N_size_i=8, row=1, col=1, data(m,n)=m*16+n, out_ready_i=1.
  - Required: out_valid_o is high the cycle after the push.
  - 16 words, addresses 36,37,38,39,44,...,63, data 0..3,16..19,...,48..51.
  - Then busy_o=0 and tiles_pending_o=0.
- Back-pressure: same tile, out_ready_i toggling 1,0,0,1,...
  - Required: addr/data held while stalled; exactly 16 handshakes, in order, with no duplicates.
- Back-to-back tiles: two pushes 3 cycles apart, out_ready_i=1.
  - Required: 32 consecutive valid cycles with no bubble at the tile boundary.
  - The second tile's first address is computed from its own row/col.
- Overflow: Depth=2, out_ready_i=0, three pushes.
  - Required: tile_ready_o=0 after the second push; the third is dropped; overflow_o=1 and stays 1.
  - tiles_pending_o=2. Releasing out_ready_i drains exactly 32 words.
- Reset mid-drain: assert rst_i after 5 handshakes.
  - Required: next cycle all outputs 0, tiles_pending_o=0, overflow_o=0.
  - A new push restarts at (0,0).
- Address wrap: AddrWidth=8, N_size_i=200, row=1, col=0.
  - Required: first address = (4*200) mod 256 = 32.
